// File: rtl/hazard_unit.sv
// Pipeline hazard control: E-stage operand forwarding, load-use bubbles and
// data-memory handshake sequencing with a bounded wait and a saturating stall counter.
module hazard_unit #(
    parameter int MAX_WAIT    = 16,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             rs1_D,
    input  logic [4:0]             rs2_D,
    input  logic [4:0]             rs1_E,
    input  logic [4:0]             rs2_E,
    input  logic [4:0]             rd_E,
    input  logic [4:0]             rd_M,
    input  logic [4:0]             rd_W,
    input  logic                   ctrl_register_file_WE_E,
    input  logic                   ctrl_register_file_WE_M,
    input  logic                   ctrl_register_file_WE_W,
    input  logic                   ctrl_result_E,
    input  logic                   ctrl_result_M,
    input  logic                   ctrl_data_memory_WE_M,
    input  logic                   mem_ready,
    output logic                   mem_req,
    output logic                   stall_F,
    output logic                   stall_D,
    output logic                   stall_E,
    output logic                   stall_M,
    output logic                   stall_W,
    output logic                   flush_E,
    output logic [1:0]             forward_A_E,
    output logic [1:0]             forward_B_E,
    output logic                   mem_timeout,
    output logic [COUNT_WIDTH-1:0] stall_count
);

    localparam int              WW        = $clog2(MAX_WAIT);
    localparam logic [WW-1:0]   WAIT_LAST = WW'(MAX_WAIT - 1);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t                   state_q, state_d;
    logic [WW-1:0]            wait_cnt_q, wait_cnt_d;
    logic                     mem_timeout_q, mem_timeout_d;
    logic [COUNT_WIDTH-1:0]   stall_count_q, stall_count_d;

    logic                     mem_access_M;
    logic                     load_use;
    logic                     mem_stall;
    logic                     req;
    logic                     any_stall;

    logic [1:0][4:0]          rs_E;
    logic [1:0][1:0]          fwd_sel;

    assign rs_E = {rs2_E, rs1_E};

    // M-stage result wins over W-stage result; x0 is never forwarded.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        assign fwd_sel[gi] =
            (ctrl_register_file_WE_M && rd_M != 5'd0 && rd_M == rs_E[gi]) ? 2'b10 :
            (ctrl_register_file_WE_W && rd_W != 5'd0 && rd_W == rs_E[gi]) ? 2'b01 :
                                                                             2'b00;
    end

    assign forward_A_E = fwd_sel[0];
    assign forward_B_E = fwd_sel[1];

    assign mem_access_M = ctrl_result_M | ctrl_data_memory_WE_M;
    assign load_use     = ctrl_result_E & ctrl_register_file_WE_E & (rd_E != 5'd0) &
                          ((rd_E == rs1_D) | (rd_E == rs2_D));

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        mem_stall     = 1'b0;
        req           = 1'b0;
        case (state_q)
            RUN: begin
                req = mem_access_M;
                if (mem_access_M && !mem_ready) begin
                    mem_stall  = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                req = 1'b1;
                if (mem_ready) begin
                    state_d = RUN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // Abandon the access: release the pipeline with the request still up.
                    state_d       = RUN;
                    mem_timeout_d = 1'b1;
                end else begin
                    mem_stall  = 1'b1;
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            default: state_d = RUN;
        endcase

        any_stall     = mem_stall | load_use;
        stall_count_d = stall_count_q;
        if (any_stall && stall_count_q != {COUNT_WIDTH{1'b1}}) begin
            stall_count_d = stall_count_q + COUNT_WIDTH'(1);
        end
    end

    // Reset gates the control outputs so nothing moves while it is asserted.
    assign mem_req = req & ~rst;
    assign stall_F = (mem_stall | load_use) & ~rst;
    assign stall_D = (mem_stall | load_use) & ~rst;
    assign stall_E = mem_stall & ~rst;
    assign stall_M = mem_stall & ~rst;
    assign stall_W = mem_stall & ~rst;
    assign flush_E = load_use & ~mem_stall & ~rst;

    assign mem_timeout = mem_timeout_q;
    assign stall_count = stall_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_hazard_unit;

    localparam int MAXW = 4;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
        logic       we_E, we_M, we_W, res_E, res_M, dwe_M, ready;
    } stim_t;

    logic          clk, rst;
    logic [4:0]    rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic          we_E, we_M, we_W, res_E, res_M, dwe_M, mem_ready;
    logic          mem_req, stall_F, stall_D, stall_E, stall_M, stall_W, flush_E;
    logic [1:0]    forward_A_E, forward_B_E;
    logic          mem_timeout;
    logic [CW-1:0] stall_count;

    int n_checks = 0;
    int n_pass   = 0;
    int txn      = 0;

    // Model state: consecutive frozen cycles of the current access, timeout flag, stall count.
    int frozen_m  = 0;
    bit timeout_m = 0;
    int count_m   = 0;

    hazard_unit #(.MAX_WAIT(MAXW), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
        .rd_M(rd_M), .rd_W(rd_W),
        .ctrl_register_file_WE_E(we_E), .ctrl_register_file_WE_M(we_M),
        .ctrl_register_file_WE_W(we_W), .ctrl_result_E(res_E),
        .ctrl_result_M(res_M), .ctrl_data_memory_WE_M(dwe_M),
        .mem_ready(mem_ready), .mem_req(mem_req),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E),
        .stall_M(stall_M), .stall_W(stall_W), .flush_E(flush_E),
        .forward_A_E(forward_A_E), .forward_B_E(forward_B_E),
        .mem_timeout(mem_timeout), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs, input stim_t s);
        if (s.we_M && s.rd_M != 0 && s.rd_M == rs) return 2'b10;
        if (s.we_W && s.rd_W != 0 && s.rd_W == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Called just after a falling edge: checks registered outputs, applies s,
    // checks the combinational outputs, then advances the model by one clock.
    task automatic drive_check(input stim_t s);
        bit acc, busy, ms, lu;
        check("stall_count", 64'(stall_count), 64'(count_m));
        check("mem_timeout", 64'(mem_timeout), 64'(timeout_m));
        rs1_D = s.rs1_D; rs2_D = s.rs2_D; rs1_E = s.rs1_E; rs2_E = s.rs2_E;
        rd_E = s.rd_E; rd_M = s.rd_M; rd_W = s.rd_W;
        we_E = s.we_E; we_M = s.we_M; we_W = s.we_W;
        res_E = s.res_E; res_M = s.res_M; dwe_M = s.dwe_M; mem_ready = s.ready;
        #1;
        acc  = s.res_M | s.dwe_M;
        busy = (frozen_m > 0) || acc;
        ms   = busy && !s.ready && (frozen_m < MAXW);
        lu   = s.res_E && s.we_E && s.rd_E != 0 && (s.rd_E == s.rs1_D || s.rd_E == s.rs2_D);
        check("forward_A", 64'(forward_A_E), 64'(exp_fwd(s.rs1_E, s)));
        check("forward_B", 64'(forward_B_E), 64'(exp_fwd(s.rs2_E, s)));
        check("mem_req", 64'(mem_req), 64'(busy));
        check("stall_F", 64'(stall_F), 64'(ms | lu));
        check("stall_D", 64'(stall_D), 64'(ms | lu));
        check("stall_E", 64'(stall_E), 64'(ms));
        check("stall_M", 64'(stall_M), 64'(ms));
        check("stall_W", 64'(stall_W), 64'(ms));
        check("flush_E", 64'(flush_E), 64'(!ms && lu));
        $display("txn %0d: acc=%b rdy=%b fA=%b fB=%b stall=%b%b%b%b%b flush=%b req=%b cnt=%0d to=%b",
                 txn, acc, s.ready, forward_A_E, forward_B_E, stall_F, stall_D, stall_E,
                 stall_M, stall_W, flush_E, mem_req, stall_count, mem_timeout);
        txn++;
        if ((ms || lu) && count_m < CMAX) count_m++;
        if (ms) begin
            frozen_m++;
        end else begin
            if (frozen_m == MAXW && !s.ready) timeout_m = 1;
            frozen_m = 0;
        end
    endtask

    initial begin
        stim_t s;
        s = '0;
        rst = 1'b1;
        {rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W} = '0;
        {we_E, we_M, we_W, res_E, dwe_M} = '0;
        res_M = 1'b1; mem_ready = 1'b0;
        rd_E = 5'd7; rs1_D = 5'd7; res_E = 1'b1; we_E = 1'b1;
        #12;
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_stall_F", 64'(stall_F), 64'd0);
        check("rst_flush_E", 64'(flush_E), 64'd0);
        check("rst_count", 64'(stall_count), 64'd0);
        check("rst_timeout", 64'(mem_timeout), 64'd0);
        tick();
        rst = 1'b0;

        // Forwarding priority and the x0 exclusion
        s = '0; s.rs1_E = 5; s.rd_M = 5; s.rd_W = 5; s.we_M = 1; s.we_W = 1; s.ready = 1;
        drive_check(s); check("fwd_M", 64'(forward_A_E), 64'b10); tick();
        s.we_M = 0;
        drive_check(s); check("fwd_W", 64'(forward_A_E), 64'b01); tick();
        s.we_M = 1; s.rd_M = 0; s.rd_W = 0;
        drive_check(s); check("fwd_x0", 64'(forward_A_E), 64'b00); tick();

        // Load-use: one bubble
        s = '0; s.res_E = 1; s.we_E = 1; s.rd_E = 7; s.rs2_D = 7;
        drive_check(s);
        check("lu_stall_F", 64'(stall_F), 64'd1);
        check("lu_flush_E", 64'(flush_E), 64'd1);
        tick();
        s = '0; s.rs2_D = 7;
        drive_check(s);
        check("lu_after_F", 64'(stall_F), 64'd0);
        check("lu_after_flush", 64'(flush_E), 64'd0);
        check("lu_count", 64'(stall_count), 64'd1);
        tick();

        // Zero-wait store
        s = '0; s.dwe_M = 1; s.ready = 1;
        drive_check(s);
        check("zw_req", 64'(mem_req), 64'd1);
        check("zw_stall_W", 64'(stall_W), 64'd0);
        tick();

        // Three-cycle load with a concurrent load-use hazard
        s = '0; s.res_M = 1; s.we_M = 1; s.rd_M = 9;
        s.res_E = 1; s.we_E = 1; s.rd_E = 7; s.rs1_D = 7;
        for (int i = 0; i < 3; i++) begin
            drive_check(s);
            check("ld3_stall_E", 64'(stall_E), 64'd1);
            check("ld3_flush_E", 64'(flush_E), 64'd0);
            tick();
        end
        s.ready = 1;
        drive_check(s);
        check("ld3_rel_stall_M", 64'(stall_M), 64'd0);
        check("ld3_bubble", 64'(flush_E), 64'd1);
        tick();
        s = '0; s.res_M = 1; s.we_M = 1; s.rd_M = 7; s.rs1_D = 7; s.ready = 1;
        drive_check(s);
        check("ld3_no_stall", 64'(stall_F), 64'd0);
        tick();
        check("ld3_count", 64'(stall_count), 64'd5);

        // Timeout with mem_ready held low
        s = '0; s.res_M = 1;
        for (int i = 0; i < MAXW; i++) begin
            drive_check(s);
            check("to_frozen", 64'(stall_W), 64'd1);
            tick();
        end
        drive_check(s);
        check("to_last_stall", 64'(stall_W), 64'd0);
        check("to_last_req", 64'(mem_req), 64'd1);
        tick();
        check("to_flag", 64'(mem_timeout), 64'd1);
        check("to_count", 64'(stall_count), 64'd9);
        s = '0;
        for (int i = 0; i < 3; i++) begin
            drive_check(s);
            check("to_sticky", 64'(mem_timeout), 64'd1);
            tick();
        end

        // Reset asserted in the second MEM_WAIT cycle
        s = '0; s.res_M = 1;
        for (int i = 0; i < 2; i++) begin
            drive_check(s);
            tick();
        end
        drive_check(s);
        #1 rst = 1'b1;
        #1;
        check("arst_req", 64'(mem_req), 64'd0);
        check("arst_stall_F", 64'(stall_F), 64'd0);
        check("arst_stall_W", 64'(stall_W), 64'd0);
        frozen_m = 0; timeout_m = 0; count_m = 0;
        tick();
        check("arst_count", 64'(stall_count), 64'd0);
        check("arst_timeout", 64'(mem_timeout), 64'd0);
        rst = 1'b0;
        s = '0;
        drive_check(s);
        tick();

        // Random traffic, long enough to drive the counter into saturation
        for (int i = 0; i < 800; i++) begin
            s.rs1_D = 5'($urandom_range(0, 3));
            s.rs2_D = 5'($urandom_range(0, 3));
            s.rs1_E = 5'($urandom_range(0, 3));
            s.rs2_E = 5'($urandom_range(0, 3));
            s.rd_E  = 5'($urandom_range(0, 3));
            s.rd_M  = 5'($urandom_range(0, 3));
            s.rd_W  = 5'($urandom_range(0, 3));
            s.we_E  = 1'($urandom_range(0, 1));
            s.we_M  = 1'($urandom_range(0, 1));
            s.we_W  = 1'($urandom_range(0, 1));
            s.res_E = 1'($urandom_range(0, 1));
            s.res_M = 1'($urandom_range(0, 1));
            s.dwe_M = ($urandom_range(0, 3) == 0);
            s.ready = ($urandom_range(0, 2) == 0);
            drive_check(s);
            tick();
        end
        check("final_count", 64'(stall_count), 64'(count_m));
        check("final_timeout", 64'(mem_timeout), 64'(timeout_m));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline control block for the 5-stage RISC-V core (F, D, E, M, W). It produces operand-forwarding selects for the E stage and load-use stall/bubble control. It also sequences the data-memory request/ready handshake, freezing the whole pipeline while a load or store in M waits on memory. It consumes the stage-suffixed control signals that the main decoder produces and the pipeline registers carry forward, and drives the stall/flush enables of every pipeline register.

## Interface
Parameters:
- MAX_WAIT, 16: maximum cycles a memory access may wait in MEM_WAIT before it is abandoned (≥2).
- COUNT_WIDTH, 32: width of the stall performance counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rs1_D, rs2_D  in  5 each  source registers of the instruction in D.
- rs1_E, rs2_E, rd_E  in  5 each  sources and destination of the instruction in E.
- rd_M, rd_W  in  5 each  destinations of the instructions in M and W.
- ctrl_register_file_WE_E, _M, _W  in  1 each  register-file write enable carried in E, M and W.
- ctrl_result_E  in  1  instruction in E is a load (result from data memory).
- ctrl_result_M, ctrl_data_memory_WE_M  in  1 each  load / store in M.
- mem_ready  in  1  data memory completes the current access this cycle.
- mem_req  out  1  data-memory access request.
- stall_F, stall_D, stall_E, stall_M, stall_W  out  1 each  hold the corresponding pipeline register.
- flush_E  out  1  clear the E register, inserting a bubble.
- forward_A_E, forward_B_E  out  2 each  00 = register file, 10 = ALU result from M, 01 = result from W.
- mem_timeout  out  1  sticky; an access was abandoned.
- stall_count  out  COUNT_WIDTH  cycles in which any stall_* output was high. Saturates.

## Operation
- State machine: RUN, MEM_WAIT. Internal wait_cnt, width clog2(MAX_WAIT).
- mem_access_M = ctrl_result_M | ctrl_data_memory_WE_M.
- mem_req = mem_access_M in RUN; 1 in MEM_WAIT.
- Forwarding (combinational, every state), shown for A; B is identical using rs2_E:
  - 10 if ctrl_register_file_WE_M, rd_M≠0 and rd_M==rs1_E.
  - Otherwise 01 if ctrl_register_file_WE_W, rd_W≠0 and rd_W==rs1_E.
  - Otherwise 00. M takes priority over W.
- Load-use hazard: lu = ctrl_result_E & ctrl_register_file_WE_E & rd_E≠0 & (rd_E==rs1_D | rd_E==rs2_D).
- Memory stall: ms = (RUN & mem_access_M & ~mem_ready) | (MEM_WAIT & ~mem_ready & wait_cnt≠MAX_WAIT-1).
- If ms: all five stall_* = 1 and flush_E = 0. A memory stall overrides a load-use hazard. W is held, so its register-file write repeats; the write is idempotent and keeps forwarded values stable.
- Else if lu: stall_F = stall_D = 1, flush_E = 1, stall_E/M/W = 0.
- Else all stall_* and flush_E are 0.
- Transitions:
  - RUN → MEM_WAIT when mem_access_M & ~mem_ready; wait_cnt ← 0.
  - MEM_WAIT → RUN on mem_ready, or when wait_cnt==MAX_WAIT-1 (timeout; mem_timeout ← 1 unless mem_ready is also high).
  - Otherwise wait_cnt increments.
- mem_ready in RUN with mem_access_M is a zero-wait access: no stall, no state change.
- stall_count increments by 1 at each edge where any stall_* is high. It holds at 2^COUNT_WIDTH−1.
- mem_timeout is cleared only by rst. An abandoned load writes undefined data; that outcome is the accepted consequence of a timeout.

## Timing
- Forwarding, stall, flush and mem_req are combinational from inputs and state, and are valid in the same cycle.
- Reset (asynchronous): state = RUN, wait_cnt = 0, mem_timeout = 0, stall_count = 0. While rst is high, mem_req and all stall_* and flush_E outputs are forced to 0.
- Reset asserted mid-MEM_WAIT aborts immediately: mem_req drops asynchronously and mem_timeout is not set.
- Memory latency N cycles (mem_ready first high N cycles after mem_req rises, N≥1): the pipeline is frozen for exactly N cycles and advances at the edge where mem_ready is high.
- Maximum freeze is MAX_WAIT cycles: at the last MEM_WAIT cycle the stalls drop with mem_req still high, and state returns to RUN.
- A load-use hazard costs exactly 1 bubble cycle. Back-to-back load-use pairs cost 1 bubble each.

## Test plan
- Forwarding: E has rs1_E=5, M writes rd_M=5, W writes rd_W=5 → forward_A_E=10. Drop WE_M → 01. Set rd_M=rd_W=0 → 00.
- Load-use: E is a load with rd_E=7 and D has rs2_D=7 → for one cycle stall_F=stall_D=flush_E=1; the next cycle all are 0; stall_count=1.
- Zero-wait store: ctrl_data_memory_WE_M=1 with mem_ready=1 in the same cycle → mem_req=1, no stall, state stays RUN.
- Three-cycle load: mem_ready rises 3 cycles after mem_req → all stall_* high for 3 cycles. A concurrent load-use hazard gives flush_E=0 during the wait and exactly 1 bubble after it. stall_count=4.
- Timeout, MAX_WAIT=4, mem_ready held 0 → 4 frozen cycles, then mem_timeout=1 and RUN. mem_timeout stays 1 until rst.
- Reset asserted in cycle 2 of MEM_WAIT → outputs drop immediately; after release, state is RUN, stall_count=0 and mem_timeout=0.
